// File: rtl/fir_pkg.sv
// Shared FIR constants and the result-drain FSM state type.
package fir_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_REGS   = 8;
  localparam int Q_FORMAT   = 8;
  localparam int SCALE      = 1 << Q_FORMAT;

  typedef enum logic {
    DRAIN_WARMUP = 1'b0,
    DRAIN_RUN    = 1'b1
  } drain_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head word is visible on rdata while empty is low.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; clear wins over any push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; a push into a full FIFO only lands when the head is leaving.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fir_result_drain.sv
// Consumes FIR results: skips warm-up outputs, decimates, buffers in a FWFT FIFO.
module fir_result_drain #(
  parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = fir_pkg::NUM_REGS,
  parameter int WARMUP     = NUM_REGS - 1,
  parameter int DEPTH      = 16,
  parameter int DECIM_W    = 4,
  parameter int CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [DATA_WIDTH-1:0]      macResult,
  input  logic                       resultIsValid,
  input  logic [DECIM_W-1:0]         decimFactor,
  output logic [DATA_WIDTH-1:0]      outData,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [$clog2(DEPTH):0]     fifoCount,
  output logic [CNT_W-1:0]           dropCount,
  output logic                       overflow
);

  import fir_pkg::*;

  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam drain_state_e START = (WARMUP == 0) ? DRAIN_RUN : DRAIN_WARMUP;

  drain_state_e      state;
  drain_state_e      state_nxt;
  logic [WW-1:0]     warm_cnt;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] decim_cnt;
  logic              in_run;
  logic              decim_wrap;
  logic              keep;
  logic              push;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  assign in_run     = (state == DRAIN_RUN);
  assign decim_wrap = (decim_q <= DECIM_W'(1)) || (decim_cnt == decim_q - 1'b1);
  assign keep       = resultIsValid && in_run && (decim_cnt == '0) && !clear;
  assign outValid   = !fifo_empty;
  assign pop        = outValid && outReady;
  assign push       = keep && (!fifo_full || pop);
  assign drop       = keep && fifo_full && !pop;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= START;
    else     state <= state_nxt;
  end

  // Next state: leave warm-up as the last discarded result is consumed.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = START;
    end else if (state == DRAIN_WARMUP && resultIsValid && warm_cnt == WW'(WARMUP - 1)) begin
      state_nxt = DRAIN_RUN;
    end
  end

  // Count discarded warm-up results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       warm_cnt <= '0;
    else if (clear)                                warm_cnt <= '0;
    else if (state == DRAIN_WARMUP && resultIsValid) warm_cnt <= warm_cnt + 1'b1;
  end

  // Decimation phase; a new factor restarts the phase so the next result is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decim_q   <= '0;
      decim_cnt <= '0;
    end else if (clear) begin
      decim_q   <= '0;
      decim_cnt <= '0;
    end else begin
      decim_q <= decimFactor;
      if (decimFactor != decim_q)        decim_cnt <= '0;
      else if (in_run && resultIsValid)  decim_cnt <= decim_wrap ? '0 : decim_cnt + 1'b1;
    end
  end

  // Drop accounting: saturating counter plus sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropCount <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      dropCount <= '0;
      overflow  <= 1'b0;
    end else if (drop) begin
      if (dropCount != '1) dropCount <= dropCount + 1'b1;
      overflow <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (macResult),
    .rdata (outData),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifoCount)
  );

endmodule

// File: tb/tb_fir_result_drain.sv
// Directed bench for fir_result_drain with a queue-based output scoreboard.
module tb_fir_result_drain;

  localparam int SC = fir_pkg::SCALE;

  logic               clk;
  logic               rst;
  logic               clear;
  logic signed [15:0] macResult;
  logic               resultIsValid;
  logic [3:0]         decimFactor;
  logic [15:0]        outData;
  logic               outValid;
  logic               outReady;
  logic [4:0]         fifoCount;
  logic [7:0]         dropCount;
  logic               overflow;

  int total = 0;
  int bad   = 0;
  int maxcnt = 0;
  logic signed [15:0] expq [$];

  fir_result_drain #(
    .DATA_WIDTH (16),
    .NUM_REGS   (8),
    .WARMUP     (7),
    .DEPTH      (16),
    .DECIM_W    (4),
    .CNT_W      (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .macResult     (macResult),
    .resultIsValid (resultIsValid),
    .decimFactor   (decimFactor),
    .outData       (outData),
    .outValid      (outValid),
    .outReady      (outReady),
    .fifoCount     (fifoCount),
    .dropCount     (dropCount),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Pops the scoreboard whenever the DUT hands a word downstream.
  task automatic monitor();
    logic signed [15:0] e;
    forever begin
      @(negedge clk);
      if (int'(fifoCount) > maxcnt) maxcnt = int'(fifoCount);
      if (!rst && outValid && outReady) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got %0d expected none", $signed(outData));
        end else begin
          e = expq.pop_front();
          if (outData !== e) begin
            bad++;
            $display("FAIL out_data: got %0d expected %0d", $signed(outData), e);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] d);
    resultIsValid = 1'b1;
    macResult     = d;
    tick();
    resultIsValid = 1'b0;
    macResult     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; macResult = '0; resultIsValid = 1'b0;
    decimFactor = 4'd1; outReady = 1'b0;
    fork
      monitor();
    join_none
    tick(); tick();
    chk("rst_outValid", int'(outValid), 0);
    chk("rst_outData", int'(outData), 0);
    chk("rst_fifoCount", int'(fifoCount), 0);
    chk("rst_dropCount", int'(dropCount), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    tick();

    // 1: warm-up discard, then streaming through with ready high
    outReady = 1'b1;
    maxcnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i > 7) expq.push_back(16'(i * SC));
      send(16'(i * SC));
    end
    idle(3);
    chk("t1_maxcount", maxcnt, 1);
    chk("t1_dropCount", int'(dropCount), 0);
    chk("t1_outValid", int'(outValid), 0);
    chk("t1_pending", expq.size(), 0);

    // 2: overfill with ready low, then drain
    outReady = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) send(16'sd100);
    for (int k = 1; k <= 20; k++) begin
      if (k <= 16) expq.push_back(16'(k * SC));
      send(16'(k * SC));
    end
    chk("t2_fifoCount", int'(fifoCount), 16);
    chk("t2_dropCount", int'(dropCount), 4);
    chk("t2_overflow", int'(overflow), 1);
    chk("t2_outValid_full", int'(outValid), 1);
    outReady = 1'b1;
    idle(20);
    chk("t2_outValid_drained", int'(outValid), 0);
    chk("t2_fifoCount_drained", int'(fifoCount), 0);
    chk("t2_overflow_sticky", int'(overflow), 1);
    chk("t2_pending", expq.size(), 0);

    // 3: decimate by 3, then switch to 2 mid-run
    decimFactor = 4'd3;
    do_reset();
    for (int i = 0; i < 7; i++) send(16'sd55);
    for (int k = 1; k <= 11; k++) begin
      if (k == 1 || k == 4 || k == 7 || k == 10) expq.push_back(16'(k * SC));
      send(16'(k * SC));
    end
    decimFactor = 4'd2;
    idle(1);
    expq.push_back(16'(12 * SC)); send(16'(12 * SC));
    send(16'(13 * SC));
    expq.push_back(16'(14 * SC)); send(16'(14 * SC));
    idle(3);
    chk("t3_pending", expq.size(), 0);
    chk("t3_dropCount", int'(dropCount), 0);

    // 4: full FIFO with simultaneous push and pop
    decimFactor = 4'd1;
    outReady = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) send(16'sd7);
    for (int k = 1; k <= 16; k++) begin
      expq.push_back(16'(-(k * SC)));
      send(16'(-(k * SC)));
    end
    chk("t4_fifoCount_full", int'(fifoCount), 16);
    expq.push_back(16'sh7FFF);
    outReady = 1'b1;
    send(16'sh7FFF);
    chk("t4_fifoCount_pushpop", int'(fifoCount), 16);
    chk("t4_dropCount", int'(dropCount), 0);
    chk("t4_overflow", int'(overflow), 0);
    idle(20);
    chk("t4_pending", expq.size(), 0);
    chk("t4_outValid", int'(outValid), 0);

    // 5: asynchronous reset with words buffered
    outReady = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) send(16'sd9);
    for (int k = 1; k <= 5; k++) send(16'(k * SC));
    chk("t5_fifoCount_buffered", int'(fifoCount), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_outValid_async", int'(outValid), 0);
    chk("t5_fifoCount_async", int'(fifoCount), 0);
    tick();
    rst = 1'b0;
    outReady = 1'b1;
    for (int i = 1; i <= 7; i++) send(16'(200 + i));
    expq.push_back(16'(21 * SC)); send(16'(21 * SC));
    expq.push_back(16'(22 * SC)); send(16'(22 * SC));
    idle(3);
    chk("t5_pending", expq.size(), 0);
    chk("t5_fifoCount_end", int'(fifoCount), 0);

    // 6: clear colliding with a kept result while overflow is set
    outReady = 1'b0;
    for (int k = 1; k <= 17; k++) send(16'(30 + k));
    chk("t6_overflow_pre", int'(overflow), 1);
    chk("t6_dropCount_pre", int'(dropCount), 1);
    chk("t6_fifoCount_pre", int'(fifoCount), 16);
    clear = 1'b1;
    send(16'sd999);
    clear = 1'b0;
    chk("t6_fifoCount_clear", int'(fifoCount), 0);
    chk("t6_outValid_clear", int'(outValid), 0);
    chk("t6_overflow_clear", int'(overflow), 0);
    chk("t6_dropCount_clear", int'(dropCount), 0);
    chk("t6_outData_clear", int'(outData), 0);
    outReady = 1'b1;
    for (int i = 1; i <= 7; i++) send(16'(300 + i));
    expq.push_back(16'(40 * SC)); send(16'(40 * SC));
    idle(3);
    chk("t6_pending", expq.size(), 0);
    chk("t6_outValid_end", int'(outValid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_result_drain.md
Name: fir_result_drain

Overview:
Output-side consumer of the FIR accelerator's result interface (macResult / resultIsValid). It discards warm-up results until the tap window is full and applies optional integer decimation. Kept results go into a first-word-fall-through FIFO, which drains to a downstream sink over a valid/ready handshake. It sits directly after the FIR top and reports drops and overflow to control logic.

Parameters:
DATA_WIDTH, 16, result word width; matches the FIR datapath.
NUM_REGS, 8, FIR tap count.
WARMUP, NUM_REGS-1 (7), number of valid results discarded after reset or clear; 0 disables discarding.
DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
DECIM_W, 4, width of the decimation factor.
CNT_W, 8, width of the drop counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
clear  in  1  synchronous soft reset; same effect as rst, applied at the clock edge.
macResult  in  DATA_WIDTH  signed result from the FIR top.
resultIsValid  in  1  macResult is valid this cycle; single-cycle qualifier, no backpressure upstream.
decimFactor  in  DECIM_W  keep 1 of N results; 0 and 1 both mean keep all.
outData  out  DATA_WIDTH  FIFO head word (signed).
outValid  out  1  FIFO is non-empty.
outReady  in  1  downstream accepts outData this cycle.
fifoCount  out  $clog2(DEPTH)+1  current occupancy.
dropCount  out  CNT_W  results lost to a full FIFO; saturates at all-ones.
overflow  out  1  sticky flag: at least one drop since reset or clear.

Behaviour:
- Reset (rst high, asynchronous): all outputs 0; FIFO emptied; pointers 0; decimation counter 0; FSM to WARMUP (or RUN if WARMUP=0).
- clear: identical effect at the clock edge. clear takes priority over any push or pop in the same cycle.
- FSM:
  - WARMUP: each resultIsValid increments warmupCnt and the result is discarded. Transition to RUN on the edge where the WARMUP-th valid result is consumed.
  - RUN: stays in RUN until rst or clear.
- Decimation (RUN only):
  - decimCnt advances on each valid result. A result is kept when decimCnt==0.
  - decimCnt wraps to 0 after reaching decimFactor-1. The first post-warmup result is always kept.
  - decimFactor is registered. Any change resets decimCnt to 0 on the following edge.
- Push: a kept result is written when the FIFO is not full, or when it is full and a pop occurs in the same cycle (pop frees the slot).
- Drop: otherwise a kept result is dropped; dropCount increments (saturating) and overflow is set.
- Pop: occurs when outValid && outReady. outData changes only on a pop or on the push into an empty FIFO.
- Latency: a result pushed into an empty FIFO at edge t gives outValid=1 and outData equal to that result after edge t. No combinational path from macResult to outData.
- Simultaneous push and pop: fifoCount unchanged. When empty, push without pop only (pop impossible).
- Pointers: ($clog2(DEPTH)+1)-bit with a wrap bit. Full = addresses equal and wrap bits differ. Empty = pointers equal.
- Data: stored and emitted bit-exact; no rounding or saturation.
- Reset mid-stream: FIFO contents lost, outValid drops asynchronously, warm-up restarts.

Decomposition:
- Shared package fir_pkg: DATA_WIDTH, NUM_REGS, Q_FORMAT, SCALE, and the drain FSM state enum (WARMUP, RUN).
- One sub-module, sync_fifo_fwft: parameterised on width and depth, with push, pop, full, empty and count. The top holds the FSM, decimation logic and counters.

Test Plan:
1. rst, then 10 valid results 1..10 (Q-format), decimFactor=1, outReady=1 -> results 1..7 discarded; outputs 8, 9, 10 in order; fifoCount never exceeds 1; dropCount=0.
2. outReady=0, 7 warm-up results then 20 results 1..20 -> fifoCount=16, dropCount=4, overflow=1. Then outReady=1 -> outputs 1..16 in order, outValid=0 after 16 pops, overflow stays 1.
3. decimFactor=3, post-warm-up results 1..9 -> outputs 1, 4, 7 only. Changing decimFactor to 2 mid-run -> the next result is kept.
4. FIFO full (16 entries), resultIsValid and outReady both high for 1 cycle -> fifoCount stays 16, dropCount unchanged, new value is last out.
5. 5 entries buffered, rst pulsed between clock edges -> outValid=0 and fifoCount=0 immediately; next 7 results are discarded.
6. clear high in the same cycle as a kept resultIsValid and with overflow=1 -> input discarded, overflow=0, dropCount=0, FSM back in WARMUP.
